// File: rtl/cpu_pkg.sv
// Shared Tomasulo core types: reorder buffer sizing and the per-entry record.
package cpu_pkg;

  localparam int unsigned ROB_ID_WIDTH = 5;
  localparam int unsigned ROB_DEPTH    = 1 << ROB_ID_WIDTH;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_ID_WIDTH = 5;

  typedef struct packed {
    logic                    busy;
    logic                    ready;
    logic                    has_dest;
    logic [REG_ID_WIDTH-1:0] rd;
    logic [XLEN-1:0]         value;
    logic                    is_branch;
    logic                    pred_taken;
    logic                    taken;
    logic [XLEN-1:0]         alt_pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates on issue, collects CDB results, retires in order
// and raises a one-cycle flush when a mispredicted branch reaches the head.
module reorder_buffer
  import cpu_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    _issue_valid,
  input  logic                    _issue_has_dest,
  input  logic [REG_ID_WIDTH-1:0] _issue_rd,
  input  logic                    _issue_is_branch,
  input  logic                    _issue_pred_taken,
  input  logic [XLEN-1:0]         _issue_alt_pc,
  output logic [ROB_ID_WIDTH-1:0] _issue_rob_id,
  output logic                    _full,
  input  logic                    _cdb_valid,
  input  logic [ROB_ID_WIDTH-1:0] _cdb_rob_id,
  input  logic [XLEN-1:0]         _cdb_value,
  input  logic                    _cdb_taken,
  input  logic [ROB_ID_WIDTH-1:0] _query_rob_id_1,
  input  logic [ROB_ID_WIDTH-1:0] _query_rob_id_2,
  output logic                    _query_ready_1,
  output logic                    _query_ready_2,
  output logic [XLEN-1:0]         _query_value_1,
  output logic [XLEN-1:0]         _query_value_2,
  output logic                    _rob_launch_ready,
  output logic [ROB_ID_WIDTH-1:0] _rob_launch_rob_id,
  output logic [REG_ID_WIDTH-1:0] _rob_launch_register_id,
  output logic                    _rob_commit_ready,
  output logic [ROB_ID_WIDTH-1:0] _rob_commit_rob_id,
  output logic [REG_ID_WIDTH-1:0] _rob_commit_register_id,
  output logic [XLEN-1:0]         _rob_commit_value,
  output logic                    _flush_valid,
  output logic [XLEN-1:0]         _flush_pc
);

  localparam int unsigned CountW = ROB_ID_WIDTH + 1;

  rob_entry_t entries_q [ROB_DEPTH];
  rob_entry_t entries_d [ROB_DEPTH];

  logic [ROB_ID_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CountW-1:0]       count_q, count_d;
  logic                    commit_ready_q, commit_ready_d;
  logic [ROB_ID_WIDTH-1:0] commit_rob_id_q, commit_rob_id_d;
  logic [REG_ID_WIDTH-1:0] commit_register_id_q, commit_register_id_d;
  logic [XLEN-1:0]         commit_value_q, commit_value_d;
  logic                    flush_valid_q, flush_valid_d;
  logic [XLEN-1:0]         flush_pc_q, flush_pc_d;

  rob_entry_t head_entry;
  logic       accept, commit_fire, mispredict, cdb_write, fwd_1, fwd_2;

  assign head_entry  = entries_q[head_q];
  assign _full       = (count_q == CountW'(ROB_DEPTH));
  assign accept      = rdy_in && rst_in && _issue_valid && !_full && !flush_valid_q;
  assign commit_fire = rdy_in && rst_in && (count_q != '0) && head_entry.ready;
  assign mispredict  = commit_fire && head_entry.is_branch &&
                       (head_entry.taken != head_entry.pred_taken);
  // Late broadcasts for already-retired or flushed entries must not resurrect them.
  assign cdb_write   = rdy_in && _cdb_valid && !flush_valid_q && entries_q[_cdb_rob_id].busy;

  assign _issue_rob_id           = tail_q;
  assign _rob_launch_ready       = accept && _issue_has_dest && (_issue_rd != '0);
  assign _rob_launch_rob_id      = tail_q;
  assign _rob_launch_register_id = _issue_rd;

  assign fwd_1          = _cdb_valid && (_cdb_rob_id == _query_rob_id_1);
  assign fwd_2          = _cdb_valid && (_cdb_rob_id == _query_rob_id_2);
  assign _query_ready_1 = fwd_1 || (entries_q[_query_rob_id_1].busy &&
                                    entries_q[_query_rob_id_1].ready);
  assign _query_ready_2 = fwd_2 || (entries_q[_query_rob_id_2].busy &&
                                    entries_q[_query_rob_id_2].ready);
  assign _query_value_1 = fwd_1 ? _cdb_value : entries_q[_query_rob_id_1].value;
  assign _query_value_2 = fwd_2 ? _cdb_value : entries_q[_query_rob_id_2].value;

  assign _rob_commit_ready       = commit_ready_q;
  assign _rob_commit_rob_id      = commit_rob_id_q;
  assign _rob_commit_register_id = commit_register_id_q;
  assign _rob_commit_value       = commit_value_q;
  assign _flush_valid            = flush_valid_q;
  assign _flush_pc               = flush_pc_q;

  always_comb begin
    entries_d            = entries_q;
    head_d               = head_q;
    tail_d               = tail_q;
    count_d              = count_q;
    commit_ready_d       = 1'b0;
    commit_rob_id_d      = commit_rob_id_q;
    commit_register_id_d = commit_register_id_q;
    commit_value_d       = commit_value_q;
    flush_valid_d        = 1'b0;
    flush_pc_d           = flush_pc_q;

    if (cdb_write) begin
      entries_d[_cdb_rob_id].ready = 1'b1;
      entries_d[_cdb_rob_id].value = _cdb_value;
      entries_d[_cdb_rob_id].taken = _cdb_taken;
    end

    if (accept) begin
      entries_d[tail_q].busy       = 1'b1;
      entries_d[tail_q].ready      = 1'b0;
      entries_d[tail_q].has_dest   = _issue_has_dest;
      entries_d[tail_q].rd         = _issue_rd;
      entries_d[tail_q].value      = '0;
      entries_d[tail_q].is_branch  = _issue_is_branch;
      entries_d[tail_q].pred_taken = _issue_pred_taken;
      entries_d[tail_q].taken      = 1'b0;
      entries_d[tail_q].alt_pc     = _issue_alt_pc;
      tail_d                       = tail_q + ROB_ID_WIDTH'(1);
    end

    if (commit_fire) begin
      entries_d[head_q].busy  = 1'b0;
      entries_d[head_q].ready = 1'b0;
      head_d                  = head_q + ROB_ID_WIDTH'(1);
      if (!head_entry.is_branch) begin
        commit_ready_d       = head_entry.has_dest && (head_entry.rd != '0);
        commit_rob_id_d      = head_q;
        commit_register_id_d = head_entry.rd;
        commit_value_d       = head_entry.value;
      end
    end

    if (accept && !commit_fire) begin
      count_d = count_q + CountW'(1);
    end else if (!accept && commit_fire) begin
      count_d = count_q - CountW'(1);
    end

    // Squash everything, including an issue landing on the same edge.
    if (mispredict) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i].busy  = 1'b0;
        entries_d[i].ready = 1'b0;
      end
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      flush_valid_d = 1'b1;
      flush_pc_d    = head_entry.alt_pc;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q               <= '0;
      tail_q               <= '0;
      count_q              <= '0;
      commit_ready_q       <= 1'b0;
      commit_rob_id_q      <= '0;
      commit_register_id_q <= '0;
      commit_value_q       <= '0;
      flush_valid_q        <= 1'b0;
      flush_pc_q           <= '0;
    end else begin
      entries_q            <= entries_d;
      head_q               <= head_d;
      tail_q               <= tail_d;
      count_q              <= count_d;
      commit_ready_q       <= commit_ready_d;
      commit_rob_id_q      <= commit_rob_id_d;
      commit_register_id_q <= commit_register_id_d;
      commit_value_q       <= commit_value_d;
      flush_valid_q        <= flush_valid_d;
      flush_pc_q           <= flush_pc_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, wrap, in-order retire, forwarding,
// mispredict flush, rd=0 handling and rdy_in stalls.
module tb_reorder_buffer;
  import cpu_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic                    rdy;
  logic                    issue_valid, issue_has_dest, issue_is_branch, issue_pred_taken;
  logic [REG_ID_WIDTH-1:0] issue_rd;
  logic [XLEN-1:0]         issue_alt_pc;
  logic [ROB_ID_WIDTH-1:0] issue_rob_id;
  logic                    full;
  logic                    cdb_valid, cdb_taken;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_id;
  logic [XLEN-1:0]         cdb_value;
  logic [ROB_ID_WIDTH-1:0] query_rob_id_1, query_rob_id_2;
  logic                    query_ready_1, query_ready_2;
  logic [XLEN-1:0]         query_value_1, query_value_2;
  logic                    launch_ready;
  logic [ROB_ID_WIDTH-1:0] launch_rob_id;
  logic [REG_ID_WIDTH-1:0] launch_reg;
  logic                    commit_ready;
  logic [ROB_ID_WIDTH-1:0] commit_rob_id;
  logic [REG_ID_WIDTH-1:0] commit_reg;
  logic [XLEN-1:0]         commit_value;
  logic                    flush_valid;
  logic [XLEN-1:0]         flush_pc;

  int n_vec = 0;
  int n_err = 0;

  reorder_buffer u_dut (
    .clk_in                  (clk),
    .rst_in                  (rst_n),
    .rdy_in                  (rdy),
    ._issue_valid            (issue_valid),
    ._issue_has_dest         (issue_has_dest),
    ._issue_rd               (issue_rd),
    ._issue_is_branch        (issue_is_branch),
    ._issue_pred_taken       (issue_pred_taken),
    ._issue_alt_pc           (issue_alt_pc),
    ._issue_rob_id           (issue_rob_id),
    ._full                   (full),
    ._cdb_valid              (cdb_valid),
    ._cdb_rob_id             (cdb_rob_id),
    ._cdb_value              (cdb_value),
    ._cdb_taken              (cdb_taken),
    ._query_rob_id_1         (query_rob_id_1),
    ._query_rob_id_2         (query_rob_id_2),
    ._query_ready_1          (query_ready_1),
    ._query_ready_2          (query_ready_2),
    ._query_value_1          (query_value_1),
    ._query_value_2          (query_value_2),
    ._rob_launch_ready       (launch_ready),
    ._rob_launch_rob_id      (launch_rob_id),
    ._rob_launch_register_id (launch_reg),
    ._rob_commit_ready       (commit_ready),
    ._rob_commit_rob_id      (commit_rob_id),
    ._rob_commit_register_id (commit_reg),
    ._rob_commit_value       (commit_value),
    ._flush_valid            (flush_valid),
    ._flush_pc               (flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy = 1'b1;
    issue_valid = 1'b0; issue_has_dest = 1'b0; issue_rd = '0;
    issue_is_branch = 1'b0; issue_pred_taken = 1'b0; issue_alt_pc = '0;
    cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0; cdb_taken = 1'b0;
    query_rob_id_1 = '0; query_rob_id_2 = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drive_issue(input logic hd, input logic [4:0] rd, input logic br,
                             input logic pt, input logic [31:0] alt);
    issue_valid = 1'b1; issue_has_dest = hd; issue_rd = rd;
    issue_is_branch = br; issue_pred_taken = pt; issue_alt_pc = alt;
  endtask

  task automatic drive_cdb(input logic [4:0] id, input logic [31:0] val, input logic tk);
    cdb_valid = 1'b1; cdb_rob_id = id; cdb_value = val; cdb_taken = tk;
  endtask

  initial begin
    do_reset();
    step();
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_tail", 32'(issue_rob_id), 32'd0);
    check_eq("rst_commit_ready", 32'(commit_ready), 32'd0);
    check_eq("rst_commit_value", commit_value, 32'd0);
    check_eq("rst_flush_valid", 32'(flush_valid), 32'd0);
    check_eq("rst_flush_pc", flush_pc, 32'd0);

    // Single ADD rd=5 through issue, writeback and commit.
    drive_issue(1'b1, 5'd5, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("add_issue_id", 32'(issue_rob_id), 32'd0);
    check_eq("add_launch_ready", 32'(launch_ready), 32'd1);
    check_eq("add_launch_id", 32'(launch_rob_id), 32'd0);
    check_eq("add_launch_reg", 32'(launch_reg), 32'd5);
    step();
    issue_valid = 1'b0;
    drive_cdb(5'd0, 32'h1234, 1'b0);
    step();
    cdb_valid = 1'b0;
    check_eq("add_commit_early", 32'(commit_ready), 32'd0);
    step();
    check_eq("add_commit_ready", 32'(commit_ready), 32'd1);
    check_eq("add_commit_id", 32'(commit_rob_id), 32'd0);
    check_eq("add_commit_reg", 32'(commit_reg), 32'd5);
    check_eq("add_commit_value", commit_value, 32'h1234);
    step();
    check_eq("add_commit_pulse", 32'(commit_ready), 32'd0);

    // Fill all 32 entries, reject the 33rd, free one, wrap to id 0.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive_issue(1'b1, 5'((i % 31) + 1), 1'b0, 1'b0, 32'h0);
      #1;
      check_eq($sformatf("fill_id_%0d", i), 32'(issue_rob_id), 32'(i));
      step();
    end
    check_eq("fill_full", 32'(full), 32'd1);
    #1;
    check_eq("fill_33_launch", 32'(launch_ready), 32'd0);
    step();
    issue_valid = 1'b0;
    check_eq("fill_33_tail", 32'(issue_rob_id), 32'd0);
    check_eq("fill_33_full", 32'(full), 32'd1);
    drive_cdb(5'd0, 32'hAA, 1'b0);
    step();
    cdb_valid = 1'b0;
    step();
    check_eq("fill_commit_ready", 32'(commit_ready), 32'd1);
    check_eq("fill_commit_value", commit_value, 32'hAA);
    check_eq("fill_not_full", 32'(full), 32'd0);
    drive_issue(1'b1, 5'd7, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("wrap_launch_ready", 32'(launch_ready), 32'd1);
    check_eq("wrap_launch_id", 32'(launch_rob_id), 32'd0);
    step();
    issue_valid = 1'b0;
    check_eq("wrap_full_again", 32'(full), 32'd1);

    // Out-of-order completion, in-order retire.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_issue(1'b1, 5'(i + 1), 1'b0, 1'b0, 32'h0);
      step();
    end
    issue_valid = 1'b0;
    drive_cdb(5'd2, 32'h22, 1'b0);
    step();
    check_eq("ooo_wait_2", 32'(commit_ready), 32'd0);
    drive_cdb(5'd1, 32'h21, 1'b0);
    step();
    check_eq("ooo_wait_1", 32'(commit_ready), 32'd0);
    drive_cdb(5'd0, 32'h20, 1'b0);
    step();
    cdb_valid = 1'b0;
    check_eq("ooo_wait_0", 32'(commit_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("ooo_commit_ready_%0d", i), 32'(commit_ready), 32'd1);
      check_eq($sformatf("ooo_commit_id_%0d", i), 32'(commit_rob_id), 32'(i));
      check_eq($sformatf("ooo_commit_val_%0d", i), commit_value, 32'h20 + 32'(i));
    end
    step();
    check_eq("ooo_drained", 32'(commit_ready), 32'd0);

    // Query forwarding from the CDB in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_issue(1'b1, 5'(i + 10), 1'b0, 1'b0, 32'h0);
      step();
    end
    issue_valid = 1'b0;
    query_rob_id_1 = 5'd3;
    query_rob_id_2 = 5'd1;
    #1;
    check_eq("query_not_ready", 32'(query_ready_1), 32'd0);
    drive_cdb(5'd3, 32'hBEEF, 1'b0);
    #1;
    check_eq("query_fwd_ready", 32'(query_ready_1), 32'd1);
    check_eq("query_fwd_value", query_value_1, 32'hBEEF);
    check_eq("query_other_ready", 32'(query_ready_2), 32'd0);
    step();
    cdb_valid = 1'b0;
    #1;
    check_eq("query_stored_ready", 32'(query_ready_1), 32'd1);
    check_eq("query_stored_value", query_value_1, 32'hBEEF);

    // Mispredicted branch followed by two completed ALU ops.
    do_reset();
    drive_issue(1'b0, 5'd0, 1'b1, 1'b0, 32'h100);
    step();
    drive_issue(1'b1, 5'd6, 1'b0, 1'b0, 32'h0);
    step();
    drive_issue(1'b1, 5'd7, 1'b0, 1'b0, 32'h0);
    step();
    issue_valid = 1'b0;
    drive_cdb(5'd1, 32'h61, 1'b0);
    step();
    drive_cdb(5'd2, 32'h62, 1'b0);
    step();
    drive_cdb(5'd0, 32'h0, 1'b1);
    step();
    cdb_valid = 1'b0;
    step();
    check_eq("br_flush_valid", 32'(flush_valid), 32'd1);
    check_eq("br_flush_pc", flush_pc, 32'h100);
    check_eq("br_commit_ready", 32'(commit_ready), 32'd0);
    check_eq("br_tail_reset", 32'(issue_rob_id), 32'd0);
    check_eq("br_not_full", 32'(full), 32'd0);
    drive_issue(1'b1, 5'd8, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("br_issue_refused", 32'(launch_ready), 32'd0);
    step();
    issue_valid = 1'b0;
    check_eq("br_flush_pulse", 32'(flush_valid), 32'd0);
    check_eq("br_tail_held", 32'(issue_rob_id), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("br_no_commit_%0d", i), 32'(commit_ready), 32'd0);
    end

    // rd=0 commit is silent; rdy_in low freezes everything.
    do_reset();
    drive_issue(1'b1, 5'd0, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("rd0_launch", 32'(launch_ready), 32'd0);
    check_eq("rd0_issue_id", 32'(issue_rob_id), 32'd0);
    step();
    drive_issue(1'b1, 5'd9, 1'b0, 1'b0, 32'h0);
    step();
    issue_valid = 1'b0;
    drive_cdb(5'd0, 32'h77, 1'b0);
    step();
    rdy = 1'b0;
    drive_issue(1'b1, 5'd4, 1'b0, 1'b0, 32'h0);
    drive_cdb(5'd1, 32'h99, 1'b0);
    #1;
    check_eq("stall_launch", 32'(launch_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("stall_commit_%0d", i), 32'(commit_ready), 32'd0);
      check_eq($sformatf("stall_tail_%0d", i), 32'(issue_rob_id), 32'd2);
    end
    rdy = 1'b1;
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
    step();
    check_eq("rd0_commit_ready", 32'(commit_ready), 32'd0);
    check_eq("rd0_tail", 32'(issue_rob_id), 32'd2);
    query_rob_id_1 = 5'd1;
    #1;
    check_eq("stall_cdb_ignored", 32'(query_ready_1), 32'd0);
    drive_cdb(5'd1, 32'h91, 1'b0);
    step();
    cdb_valid = 1'b0;
    step();
    check_eq("rd0_next_ready", 32'(commit_ready), 32'd1);
    check_eq("rd0_next_id", 32'(commit_rob_id), 32'd1);
    check_eq("rd0_next_reg", 32'(commit_reg), 32'd9);
    check_eq("rd0_next_value", commit_value, 32'h91);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
